// File: rtl/vram_pkg.sv
// vram_pkg: shared constants and enumerations for the VGA character buffer
// arbiter (buffer geometry, CPU access FSM states, read-return owner tag).
`timescale 1ns/1ps
package vram_pkg;

  localparam int VRAM_AW = 12;  // 4096 character cells
  localparam int VRAM_DW = 8;   // one byte per cell

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_DRAIN = 2'd1,
    C_ARB   = 2'd2,
    C_DATA  = 2'd3
  } cpu_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VGA = 1'b1
  } owner_t;

endpackage

// File: rtl/vram_wbuf.sv
// vram_wbuf: circular posted-write FIFO holding CPU stores (address + data)
// until they win a memory slot.
// Ports:
//   clock, reset            clock / async active-low reset (empties the FIFO)
//   push, push_addr/data    enqueue one write (caller guarantees !full or pop)
//   pop                     dequeue the head entry (caller guarantees !empty)
//   full, empty             occupancy flags
//   head_addr, head_data    oldest buffered write
`timescale 1ns/1ps
module vram_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 12,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_addr = addr_q[rd_ptr[PW-1:0]];
  assign head_data = data_q[rd_ptr[PW-1:0]];

  // Pointer update; reset discards any buffered writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Entry storage; contents are meaningless while the slot is unoccupied.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[wr_ptr[PW-1:0]] <= push_addr;
      data_q[wr_ptr[PW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port 4096x8 VGA character buffer between the
// CPU MMIO path and the VGA scan-out fetch engine. CPU stores are posted into
// vram_wbuf; scan-out has priority, bounded by a starvation counter.
// Ports:
//   clock, reset                        system clock / async active-low reset
//   cpu_req/we/addr/wdata -> cpu_ready  CPU request, held until cpu_ready
//   cpu_rvalid, cpu_rdata               CPU read return pulse and data
//   vga_req/addr -> vga_gnt             scan-out fetch request and issue flag
//   vga_rvalid, vga_rdata               scan-out return, one cycle after vga_gnt
//   mem_en/we/addr/wdata, mem_rdata     single-port buffer interface (1-cycle read)
`timescale 1ns/1ps
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int WBUF_DEPTH = 4,
  parameter int MAX_STARVE = 8,
  parameter int AW         = VRAM_AW,
  parameter int DW         = VRAM_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  cpu_state_t    state;
  cpu_state_t    state_nx;
  logic [SW-1:0] starve_cnt;
  logic          rd_busy;
  owner_t        rd_owner;

  logic          wb_push;
  logic          wb_full;
  logic          wb_empty;
  logic [AW-1:0] wb_head_addr;
  logic [DW-1:0] wb_head_data;

  logic          cpu_pending;
  logic          starve_hit;
  logic          vga_win;
  logic          rd_win;
  logic          wr_win;

  vram_wbuf #(.DEPTH(WBUF_DEPTH), .AW(AW), .DW(DW)) u_wbuf (
    .clock     (clock),
    .reset     (reset),
    .push      (wb_push),
    .push_addr (cpu_addr),
    .push_data (cpu_wdata),
    .pop       (wr_win),
    .full      (wb_full),
    .empty     (wb_empty),
    .head_addr (wb_head_addr),
    .head_data (wb_head_data)
  );

  // One memory slot per cycle: starved CPU, then scan-out, then CPU read, then posted write.
  always_comb begin
    cpu_pending = (state == C_ARB) || !wb_empty;
    starve_hit  = (starve_cnt == SW'(MAX_STARVE)) && cpu_pending;
    vga_win     = 1'b0;
    rd_win      = 1'b0;
    wr_win      = 1'b0;
    if (!reset) begin
      // While reset is held nobody gets the memory, so every output reads 0.
      vga_win = 1'b0;
    end else if (starve_hit) begin
      if (state == C_ARB) rd_win = 1'b1;
      else                wr_win = 1'b1;
    end else if (vga_req) begin
      vga_win = 1'b1;
    end else if (state == C_ARB) begin
      rd_win = 1'b1;
    end else if (!wb_empty) begin
      wr_win = 1'b1;
    end else begin
      vga_win = 1'b0;
    end
  end

  // CPU access FSM: write acceptance in C_IDLE, reads wait for the buffer to drain.
  always_comb begin
    state_nx  = state;
    cpu_ready = 1'b0;
    wb_push   = 1'b0;
    case (state)
      C_IDLE: begin
        if (reset && cpu_req) begin
          if (cpu_we) begin
            if (!wb_full) begin
              cpu_ready = 1'b1;
              wb_push   = 1'b1;
            end else begin
              cpu_ready = 1'b0;
            end
          end else begin
            state_nx = wb_empty ? C_ARB : C_DRAIN;
          end
        end else begin
          state_nx = C_IDLE;
        end
      end
      C_DRAIN: begin
        if (wb_empty) state_nx = C_ARB;
        else          state_nx = C_DRAIN;
      end
      C_ARB: begin
        if (rd_win) begin
          cpu_ready = 1'b1;
          state_nx  = C_DATA;
        end else begin
          state_nx = C_ARB;
        end
      end
      C_DATA:  state_nx = C_IDLE;
      default: state_nx = C_IDLE;
    endcase
  end

  // Memory port drive for the winning requester.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    vga_gnt   = 1'b0;
    if (vga_win) begin
      mem_en   = 1'b1;
      mem_addr = vga_addr;
      vga_gnt  = 1'b1;
    end else if (rd_win) begin
      mem_en   = 1'b1;
      mem_addr = cpu_addr;
    end else if (wr_win) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wb_head_addr;
      mem_wdata = wb_head_data;
    end else begin
      mem_en = 1'b0;
    end
  end

  // CPU FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= C_IDLE;
    else        state <= state_nx;
  end

  // Starvation counter: counts slots lost to scan-out while the CPU waits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!cpu_pending || rd_win || wr_win) begin
      starve_cnt <= '0;
    end else if (vga_win && (starve_cnt != SW'(MAX_STARVE))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  // Read-return owner tag captured at issue; reset kills an in-flight return.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_busy  <= 1'b0;
      rd_owner <= OWN_CPU;
    end else begin
      rd_busy  <= vga_win || rd_win;
      rd_owner <= vga_win ? OWN_VGA : OWN_CPU;
    end
  end

  assign cpu_rvalid = rd_busy && (rd_owner == OWN_CPU);
  assign vga_rvalid = rd_busy && (rd_owner == OWN_VGA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign vga_rdata  = vga_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [11:0] cpu_addr = 12'h000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        vga_req = 1'b0;
  logic [11:0] vga_addr = 12'h000;
  logic        vga_gnt;
  logic        vga_rvalid;
  logic [7:0]  vga_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  vmem [0:4095];
  logic [11:0] log_addr [$];
  logic [7:0]  log_data [$];

  logic [11:0] wa5 [5] = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h104};
  logic [11:0] a8 [8]  = '{12'hFFF, 12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006};

  vram_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Single-port buffer model with one-cycle read latency and a write log.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        vmem[mem_addr] <= mem_wdata;
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_wdata);
      end else begin
        mem_rdata <= vmem[mem_addr];
      end
    end
  end

  task automatic drive_point();
    @(posedge clock); #1;
  endtask

  task automatic sample_point();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_point();
    sample_point();
    n_total++;
    if ({cpu_ready, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== 42'd0)
      $display("FAIL reset_outputs: got %b want 0", {cpu_ready, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata, mem_en, mem_we, mem_addr, mem_wdata});
    else n_pass++;
    drive_point();
    reset = 1'b1;
  endtask

  task automatic test_write_order();
    int base;
    base = log_addr.size();
    drive_point();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 8'h41; vga_req = 1'b0;
    sample_point();
    n_total++; if (cpu_ready !== 1'b1) $display("FAIL wr1_ready: got %b want 1", cpu_ready); else n_pass++;
    n_total++; if (mem_en !== 1'b0) $display("FAIL wr1_mem_idle: got %b want 0", mem_en); else n_pass++;
    drive_point();
    cpu_addr = 12'h011; cpu_wdata = 8'h42;
    sample_point();
    n_total++; if (cpu_ready !== 1'b1) $display("FAIL wr2_ready: got %b want 1", cpu_ready); else n_pass++;
    n_total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'h010, 8'h41})
      $display("FAIL wr1_mem: got %h want %h", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 12'h010, 8'h41}); else n_pass++;
    drive_point();
    cpu_req = 1'b0; cpu_we = 1'b0;
    sample_point();
    n_total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'h011, 8'h42})
      $display("FAIL wr2_mem: got %h want %h", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 12'h011, 8'h42}); else n_pass++;
    drive_point();
    sample_point();
    n_total++; if (mem_en !== 1'b0) $display("FAIL wr_done_idle: got %b want 0", mem_en); else n_pass++;
    n_total++; if (log_addr.size() - base !== 2) $display("FAIL wr_count: got %0d want 2", log_addr.size() - base); else n_pass++;
  endtask

  task automatic test_starve();
    int base;
    int idx;
    logic exp_bit;
    base = log_addr.size();
    idx = 0;
    vga_req = 1'b1; vga_addr = 12'h200;
    for (int k = 0; k < 11; k++) begin
      drive_point();
      cpu_req = (idx < 5); cpu_we = 1'b1;
      if (idx < 5) begin cpu_addr = wa5[idx]; cpu_wdata = 8'(8'hB0 + idx); end
      sample_point();
      exp_bit = (k != 9);
      n_total++; if (vga_gnt !== exp_bit) $display("FAIL starve_gnt_k%0d: got %b want %b", k, vga_gnt, exp_bit); else n_pass++;
      if (k < 9) begin
        exp_bit = (k < 4);
        n_total++; if (cpu_ready !== exp_bit) $display("FAIL starve_ready_k%0d: got %b want %b", k, cpu_ready, exp_bit); else n_pass++;
      end
      if (k == 9) begin
        n_total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'h100, 8'hB0})
          $display("FAIL starve_slot_mem: got %h want %h", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 12'h100, 8'hB0}); else n_pass++;
      end
      if (cpu_ready) idx++;
    end
    for (int k = 0; k < 20 && idx < 5; k++) begin
      drive_point();
      cpu_addr = wa5[idx]; cpu_wdata = 8'(8'hB0 + idx);
      sample_point();
      if (cpu_ready) idx++;
    end
    n_total++; if (idx !== 5) $display("FAIL starve_fifth_accept: got %0d accepted want 5", idx); else n_pass++;
    drive_point();
    cpu_req = 1'b0; cpu_we = 1'b0; vga_req = 1'b0;
    repeat (8) drive_point();
    n_total++; if (log_addr.size() - base !== 5) $display("FAIL starve_wr_count: got %0d want 5", log_addr.size() - base);
    else begin
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        n_total++; if ({log_addr[base+i], log_data[base+i]} !== {wa5[i], 8'(8'hB0 + i)})
          $display("FAIL starve_order_%0d: got %h want %h", i, {log_addr[base+i], log_data[base+i]}, {wa5[i], 8'(8'hB0 + i)}); else n_pass++;
      end
    end
  endtask

  task automatic test_raw();
    drive_point();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'h55;
    sample_point();
    n_total++; if (cpu_ready !== 1'b1) $display("FAIL raw_wr_ready: got %b want 1", cpu_ready); else n_pass++;
    drive_point();
    cpu_we = 1'b0;
    sample_point();
    n_total++; if (cpu_ready !== 1'b0) $display("FAIL raw_rd_wait1: got %b want 0", cpu_ready); else n_pass++;
    n_total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'h123, 8'h55})
      $display("FAIL raw_drain_mem: got %h want %h", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 12'h123, 8'h55}); else n_pass++;
    drive_point();
    sample_point();
    n_total++; if ({cpu_ready, mem_en} !== 2'b00) $display("FAIL raw_rd_wait2: got %b want 00", {cpu_ready, mem_en}); else n_pass++;
    drive_point();
    sample_point();
    n_total++; if ({cpu_ready, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 12'h123})
      $display("FAIL raw_rd_issue: got %h want %h", {cpu_ready, mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 12'h123}); else n_pass++;
    drive_point();
    cpu_req = 1'b0;
    sample_point();
    n_total++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h55}) $display("FAIL raw_rdata: got %h want %h", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h55}); else n_pass++;
    drive_point();
    sample_point();
    n_total++; if (cpu_rvalid !== 1'b0) $display("FAIL raw_rvalid_pulse: got %b want 0", cpu_rvalid); else n_pass++;
  endtask

  task automatic test_vga_read();
    drive_point();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h0FF; cpu_wdata = 8'h7A;
    drive_point();
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (2) drive_point();
    vga_req = 1'b1; vga_addr = 12'h0FF;
    sample_point();
    n_total++; if ({vga_gnt, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 12'h0FF})
      $display("FAIL vga_issue: got %h want %h", {vga_gnt, mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 12'h0FF}); else n_pass++;
    drive_point();
    vga_req = 1'b0;
    sample_point();
    n_total++; if ({vga_rvalid, vga_rdata, cpu_rvalid} !== {1'b1, 8'h7A, 1'b0})
      $display("FAIL vga_return: got %h want %h", {vga_rvalid, vga_rdata, cpu_rvalid}, {1'b1, 8'h7A, 1'b0}); else n_pass++;
    drive_point();
    sample_point();
    n_total++; if ({vga_rvalid, cpu_rvalid} !== 2'b00) $display("FAIL vga_rvalid_pulse: got %b want 00", {vga_rvalid, cpu_rvalid}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base;
    base = log_addr.size();
    vga_req = 1'b1; vga_addr = 12'h300;
    for (int k = 0; k < 3; k++) begin
      drive_point();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'(12'h400 + k); cpu_wdata = 8'(8'hC0 + k);
      sample_point();
      n_total++; if (cpu_ready !== 1'b1) $display("FAIL rst_buf_ready_%0d: got %b want 1", k, cpu_ready); else n_pass++;
    end
    drive_point();
    cpu_we = 1'b0; cpu_addr = 12'h400;
    drive_point();
    reset = 1'b0;
    sample_point();
    n_total++; if ({cpu_ready, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== 42'd0)
      $display("FAIL rst_mid_outputs: got %b want 0", {cpu_ready, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata, mem_en, mem_we, mem_addr, mem_wdata}); else n_pass++;
    drive_point();
    reset = 1'b1; vga_req = 1'b0; cpu_req = 1'b0;
    repeat (6) drive_point();
    n_total++; if (log_addr.size() !== base) $display("FAIL rst_discard: got %0d writes want 0", log_addr.size() - base); else n_pass++;
    // Read of 0x010 interrupted by reset while its data is in flight.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    drive_point();
    sample_point();
    n_total++; if ({cpu_ready, mem_en, mem_we} !== 3'b110) $display("FAIL rst_rd_issue: got %b want 110", {cpu_ready, mem_en, mem_we}); else n_pass++;
    drive_point();
    reset = 1'b0; cpu_req = 1'b0;
    sample_point();
    n_total++; if ({cpu_rvalid, cpu_rdata} !== 9'd0) $display("FAIL rst_inflight: got %h want 0", {cpu_rvalid, cpu_rdata}); else n_pass++;
    drive_point();
    reset = 1'b1;
    sample_point();
    n_total++; if (cpu_rvalid !== 1'b0) $display("FAIL rst_no_late_rvalid: got %b want 0", cpu_rvalid); else n_pass++;
    drive_point();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 8'h99;
    sample_point();
    n_total++; if (cpu_ready !== 1'b1) $display("FAIL rst_fsm_idle: got %b want 1", cpu_ready); else n_pass++;
    drive_point();
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (3) drive_point();
  endtask

  task automatic test_wrap();
    int base;
    int idx;
    base = log_addr.size();
    idx = 0;
    vga_addr = 12'h500;
    for (int k = 0; k < 30; k++) begin
      drive_point();
      vga_req = (k < 4);
      cpu_req = (idx < 8); cpu_we = 1'b1;
      if (idx < 8) begin cpu_addr = a8[idx]; cpu_wdata = 8'(8'hD0 + idx); end
      sample_point();
      if (cpu_ready) idx++;
    end
    drive_point();
    cpu_req = 1'b0; cpu_we = 1'b0; vga_req = 1'b0;
    repeat (6) drive_point();
    n_total++; if (log_addr.size() - base !== 8) $display("FAIL wrap_count: got %0d want 8", log_addr.size() - base);
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_total++; if ({log_addr[base+i], log_data[base+i]} !== {a8[i], 8'(8'hD0 + i)})
          $display("FAIL wrap_order_%0d: got %h want %h", i, {log_addr[base+i], log_data[base+i]}, {a8[i], 8'(8'hD0 + i)}); else n_pass++;
      end
    end
    n_total++; if ({vmem[12'hFFF], vmem[12'h000]} !== {8'hD0, 8'hD1})
      $display("FAIL wrap_edges: got %h want %h", {vmem[12'hFFF], vmem[12'h000]}, {8'hD0, 8'hD1}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_order();
    test_starve();
    test_raw();
    test_vga_read();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
